// File: rtl/uart_word_tx_buffer.sv
// Word FIFO feeding a byte-serial UART handshake; words are sent MSB byte first.
// Optional UART_WORD_TX_CHECKSUM_EN appends an XOR-of-bytes checksum byte per word.
module uart_word_tx_buffer #(
    parameter int WORD_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int FIFO_ADDR_BITS = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [WORD_WIDTH-1:0] i_word,
    input  logic                  i_word_start,
    output logic                  o_ready,
    output logic                  o_idle,
    output logic                  o_overflow,
    output logic [BYTE_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_done
);

    localparam int DEPTH  = 2 ** FIFO_ADDR_BITS;
    localparam int NBYTES = WORD_WIDTH / BYTE_WIDTH;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [FIFO_ADDR_BITS:0] FULL_CNT  = DEPTH[FIFO_ADDR_BITS:0];
    localparam logic [BCW-1:0]          LAST_BYTE = BCW'(NBYTES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        SEND      = 3'd2,
`ifdef UART_WORD_TX_CHECKSUM_EN
        CHKSUM    = 3'd4,
`endif
        WAIT_DONE = 3'd3
    } state_t;

    logic [WORD_WIDTH-1:0]     mem_q [DEPTH];
    logic [FIFO_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_ADDR_BITS:0]   count_q, count_d;
    logic                      overflow_q, overflow_d;

    state_t                    state_q, state_d;
    logic [WORD_WIDTH-1:0]     shift_q, shift_d;
    logic [BCW-1:0]            byte_cnt_q, byte_cnt_d;
    logic [BYTE_WIDTH-1:0]     tx_data_q, tx_data_d;
    logic                      tx_start_q, tx_start_d;

    logic                      push, pop;

    assign push = i_word_start && (count_q != FULL_CNT);
    assign pop  = (state_q == IDLE) && (count_q != '0);

    assign o_ready    = (count_q != FULL_CNT);
    assign o_idle     = (count_q == '0) && (state_q == IDLE);
    assign o_overflow = overflow_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;

    // Storage is unreset: count/pointers alone decide which entries are valid.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= i_word;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (i_word_start && !push) overflow_d = 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef UART_WORD_TX_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0] csum_q, csum_d;
    logic                  csum_sent_q, csum_sent_d;

    function automatic logic [BYTE_WIDTH-1:0] xor_bytes(input logic [WORD_WIDTH-1:0] w);
        logic [BYTE_WIDTH-1:0] acc;
        acc = '0;
        for (int i = 0; i < NBYTES; i++) acc = acc ^ w[i*BYTE_WIDTH +: BYTE_WIDTH];
        return acc;
    endfunction
`endif

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
`ifdef UART_WORD_TX_CHECKSUM_EN
        csum_d      = csum_q;
        csum_sent_d = csum_sent_q;
`endif
        case (state_q)
            IDLE: begin
                if (pop) begin
                    shift_d    = mem_q[rd_ptr_q];
                    byte_cnt_d = '0;
`ifdef UART_WORD_TX_CHECKSUM_EN
                    csum_d     = xor_bytes(mem_q[rd_ptr_q]);
`endif
                    state_d    = LOAD;
                end
            end
            // The head byte is already in shift_q, so LOAD issues it directly;
            // this puts the first start pulse two edges after the push.
            LOAD, SEND: begin
                tx_data_d  = shift_q[WORD_WIDTH-1 -: BYTE_WIDTH];
                tx_start_d = 1'b1;
                state_d    = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_tx_done) begin
                    if (byte_cnt_q == LAST_BYTE) begin
`ifdef UART_WORD_TX_CHECKSUM_EN
                        csum_sent_d = 1'b0;
                        state_d     = CHKSUM;
`else
                        state_d     = IDLE;
`endif
                    end else begin
                        shift_d    = shift_q << BYTE_WIDTH;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        state_d    = SEND;
                    end
                end
            end
`ifdef UART_WORD_TX_CHECKSUM_EN
            CHKSUM: begin
                if (!csum_sent_q) begin
                    tx_data_d   = csum_q;
                    tx_start_d  = 1'b1;
                    csum_sent_d = 1'b1;
                end else if (i_tx_done) begin
                    csum_sent_d = 1'b0;
                    state_d     = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

`ifdef UART_WORD_TX_CHECKSUM_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            csum_q      <= '0;
            csum_sent_q <= 1'b0;
        end else begin
            csum_q      <= csum_d;
            csum_sent_q <= csum_sent_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_word_tx_buffer.sv
// Directed bench for uart_word_tx_buffer: byte order, latency, FIFO full/overflow,
// stray done pulses and mid-word reset. Honours UART_WORD_TX_CHECKSUM_EN.
module tb_uart_word_tx_buffer;

`ifdef UART_WORD_TX_CHECKSUM_EN
    localparam int BPW = 5;
`else
    localparam int BPW = 4;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [31:0] i_word = '0;
    logic        i_word_start = 1'b0;
    logic        i_tx_done;
    logic        o_ready, o_idle, o_overflow, o_tx_start;
    logic [7:0]  o_tx_data;

    logic resp_done = 1'b0;
    logic man_done  = 1'b0;
    assign i_tx_done = resp_done | man_done;

    uart_word_tx_buffer dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_word       (i_word),
        .i_word_start (i_word_start),
        .o_ready      (o_ready),
        .o_idle       (o_idle),
        .o_overflow   (o_overflow),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .i_tx_done    (i_tx_done)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Log of every start pulse seen on the UART side.
    logic [7:0] bytes[$];
    int         start_cyc[$];
    logic       prev_start = 1'b0;
    logic       dbl = 1'b0;
    always @(negedge i_clk) begin
        if (o_tx_start) begin
            bytes.push_back(o_tx_data);
            start_cyc.push_back(cyc);
            if (prev_start) dbl <= 1'b1;
        end
        prev_start <= o_tx_start;
    end

    // UART model: answer each start with a done pulse a few cycles later.
    bit auto_en = 1'b0;
    int done_len = 1;
    int done_cnt = 0;
    initial begin
        forever begin
            @(negedge i_clk);
            if (auto_en && o_tx_start) begin
                repeat (3) @(posedge i_clk);
                #1 resp_done = 1'b1;
                done_cnt++;
                repeat (done_len) @(posedge i_clk);
                #1 resp_done = 1'b0;
            end
        end
    end

    logic [7:0] exp_q[$];
    int         e0;

    task automatic add_exp(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
`ifdef UART_WORD_TX_CHECKSUM_EN
        exp_q.push_back(w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]);
`endif
    endtask

    task automatic clear_log();
        @(posedge i_clk);
        #1;
        bytes.delete();
        start_cyc.delete();
        exp_q.delete();
        dbl = 1'b0;
    endtask

    // e0 records the cycle of the edge that sampled the first word.
    task automatic push_words(input logic [31:0] ws[$]);
        @(posedge i_clk);
        #1;
        foreach (ws[i]) begin
            i_word = ws[i];
            i_word_start = 1'b1;
            @(posedge i_clk);
            #1;
            if (i == 0) e0 = cyc;
        end
        i_word_start = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bytes.size() >= n) begin ok = 1'b1; break; end
            @(negedge i_clk);
        end
    endtask

    task automatic wait_done(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt >= n) begin ok = 1'b1; break; end
            @(negedge i_clk);
        end
    endtask

    task automatic apply_reset();
        @(negedge i_clk);
        auto_en = 1'b0;
        i_reset_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++; if (o_tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", o_tx_data); end
        checks++; if (o_tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b exp=0", o_tx_start); end
        checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", o_overflow); end
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        checks++; if (o_idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", o_idle); end
        i_reset_n = 1'b1;
    endtask

    task automatic test_single_word();
        bit ok;
        int base;
        clear_log();
        auto_en = 1'b1;
        base = done_cnt;
        add_exp(32'h636F6E74);
        push_words('{32'h636F6E74});
        wait_bytes(BPW, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=%0d bytes exp=%0d", bytes.size(), BPW); end
        for (int i = 0; i < BPW && i < bytes.size(); i++) begin
            checks++; if (bytes[i] !== exp_q[i]) begin failures++; $display("FAIL single_byte%0d got=%h exp=%h", i, bytes[i], exp_q[i]); end
        end
        if (start_cyc.size() > 0) begin
            checks++; if (start_cyc[0] - e0 !== 2) begin failures++; $display("FAIL first_start_latency got=%0d exp=2", start_cyc[0] - e0); end
        end
        wait_done(base + BPW, 200, ok);
        @(negedge i_clk);
        checks++; if (!ok || o_idle !== 1'b1) begin failures++; $display("FAIL single_idle_after got=%b exp=1", o_idle); end
        checks++; if (dbl !== 1'b0) begin failures++; $display("FAIL single_double_start got=%b exp=0", dbl); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int base;
        logic [31:0] ws[$];
        clear_log();
        auto_en = 1'b1;
        base = done_cnt;
        ws = '{32'h11223344, 32'h55667788, 32'hAABBCCDD, 32'hFFFFFFFF, 32'h01020304};
        foreach (ws[i]) add_exp(ws[i]);
        push_words(ws);
        @(negedge i_clk);
        // First word left the FIFO on the edge after its push, so the 5th fits.
        checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow got=%b exp=0", o_overflow); end
        wait_bytes(5 * BPW, 2000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=%0d bytes exp=%0d", bytes.size(), 5 * BPW); end
        for (int i = 0; i < 5 * BPW && i < bytes.size(); i++) begin
            checks++; if (bytes[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, bytes[i], exp_q[i]); end
        end
        wait_done(base + 5 * BPW, 200, ok);
        @(negedge i_clk);
        checks++; if (!ok || o_idle !== 1'b1) begin failures++; $display("FAIL b2b_idle_after got=%b exp=1", o_idle); end
        checks++; if (dbl !== 1'b0) begin failures++; $display("FAIL b2b_double_start got=%b exp=0", dbl); end
    endtask

    task automatic test_overflow();
        apply_reset();
        clear_log();
        push_words('{32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'hD0E0F001, 32'h02030405});
        @(negedge i_clk);
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", o_ready); end
        checks++; if (o_overflow !== 1'b0) begin failures++; $display("FAIL full_overflow_early got=%b exp=0", o_overflow); end
        push_words('{32'hDEADBEEF});
        @(negedge i_clk);
        checks++; if (o_overflow !== 1'b1) begin failures++; $display("FAIL overflow_set got=%b exp=1", o_overflow); end
        repeat (10) @(negedge i_clk);
        checks++; if (o_overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky got=%b exp=1", o_overflow); end
        checks++; if (bytes.size() !== 1) begin failures++; $display("FAIL stalled_byte_count got=%0d exp=1", bytes.size()); end
        if (bytes.size() > 0) begin
            checks++; if (bytes[0] !== 8'h10) begin failures++; $display("FAIL stalled_byte0 got=%h exp=10", bytes[0]); end
        end
        i_reset_n = 1'b0;
        @(negedge i_clk);
        checks++; if (o_overflow !== 1'b0 || o_ready !== 1'b1) begin failures++; $display("FAIL overflow_cleared got=%b/%b exp=0/1", o_overflow, o_ready); end
        i_reset_n = 1'b1;
    endtask

    task automatic test_done_ignored();
        bit ok;
        int base;
        clear_log();
        @(negedge i_clk);
        man_done = 1'b1;
        repeat (3) @(negedge i_clk);
        man_done = 1'b0;
        repeat (5) @(negedge i_clk);
        checks++; if (bytes.size() !== 0 || o_idle !== 1'b1) begin failures++; $display("FAIL idle_done got=%0d bytes idle=%b exp=0 bytes idle=1", bytes.size(), o_idle); end
        // Done held two cycles: the second cycle lands in SEND (or IDLE after the last byte).
        done_len = 2;
        auto_en = 1'b1;
        base = done_cnt;
        add_exp(32'hA1B2C3D4);
        push_words('{32'hA1B2C3D4});
        wait_done(base + BPW, 400, ok);
        repeat (12) @(negedge i_clk);
        checks++; if (!ok || bytes.size() !== BPW) begin failures++; $display("FAIL send_done_count got=%0d exp=%0d", bytes.size(), BPW); end
        for (int i = 0; i < BPW && i < bytes.size(); i++) begin
            checks++; if (bytes[i] !== exp_q[i]) begin failures++; $display("FAIL send_done_byte%0d got=%h exp=%h", i, bytes[i], exp_q[i]); end
        end
        done_len = 1;
    endtask

    task automatic test_reset_midword();
        bit ok;
        int base;
        clear_log();
        auto_en = 1'b1;
        base = done_cnt;
        push_words('{32'hCAFEBABE, 32'h12345678, 32'h9ABCDEF0});
        wait_done(base + 2, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL midword_timeout got=%0d dones exp=2", done_cnt - base); end
        @(negedge i_clk);
        auto_en = 1'b0;
        i_reset_n = 1'b0;
        @(negedge i_clk);
        checks++; if (o_tx_data !== 8'h00 || o_tx_start !== 1'b0) begin failures++; $display("FAIL midword_tx got=%h/%b exp=00/0", o_tx_data, o_tx_start); end
        checks++; if (o_ready !== 1'b1 || o_idle !== 1'b1 || o_overflow !== 1'b0) begin failures++; $display("FAIL midword_flags got=%b%b%b exp=110", o_ready, o_idle, o_overflow); end
        checks++; if (bytes.size() !== 2 || bytes[0] !== 8'hCA || bytes[1] !== 8'hFE) begin failures++; $display("FAIL midword_sent got=%0d bytes exp=2 (CA FE)", bytes.size()); end
        i_reset_n = 1'b1;
        repeat (20) @(negedge i_clk);
        checks++; if (bytes.size() !== 2) begin failures++; $display("FAIL midword_no_restart got=%0d bytes exp=2", bytes.size()); end
        auto_en = 1'b1;
        base = done_cnt;
        push_words('{32'h5A5AA5A5});
        wait_bytes(3, 100, ok);
        checks++; if (!ok || bytes[2] !== 8'h5A) begin failures++; $display("FAIL midword_resume got=%0d bytes exp=5A first", bytes.size()); end
        wait_done(base + BPW, 200, ok);
        @(negedge i_clk);
        auto_en = 1'b0;
    endtask

`ifdef UART_WORD_TX_CHECKSUM_EN
    task automatic test_checksum();
        bit ok;
        logic [7:0] cs_exp[5];
        cs_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
        clear_log();
        auto_en = 1'b1;
        push_words('{32'h01020408});
        wait_bytes(5, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL chk_timeout got=%0d bytes exp=5", bytes.size()); end
        for (int i = 0; i < 5 && i < bytes.size(); i++) begin
            checks++; if (bytes[i] !== cs_exp[i]) begin failures++; $display("FAIL chk_byte%0d got=%h exp=%h", i, bytes[i], cs_exp[i]); end
        end
        repeat (10) @(negedge i_clk);
        auto_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_overflow();
        test_done_ignored();
        test_reset_midword();
`ifdef UART_WORD_TX_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
